wb_arbiter_2x1: RTL and testbench

//  Two-master Wishbone arbiter with round-robin fairness and a bus-hang watchdog. Shares one Wishbone

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_if.sv | 18 +
 rtl/wb_arb_watchdog.sv | 43 ++++
 rtl/wb_arbiter_2x1.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter_2x1.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int ARB_NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN0  = 2'd1,
        ARB_OWN1  = 2'd2,
        ARB_ABORT = 2'd3
    } arb_state_e;

    // Hand the bus straight to the other master if it is waiting, otherwise go idle.
    function automatic arb_state_e arb_release(input logic owner,
                                               input logic m0_cyc,
                                               input logic m1_cyc);
        logic other_cyc;
        other_cyc = owner ? m0_cyc : m1_cyc;
        if (other_cyc) begin
            return owner ? ARB_OWN0 : ARB_OWN1;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle used for both requester and downstream ports.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;

    modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_arb_watchdog.sv
// Saturating no-response counter; expire_o flags the last allowed wait cycle.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Independent of clr_i so the FSM can use it without a combinational loop.
        assign expire_o = en_i && (cnt_q == LAST);
    end else begin : g_nowd
        logic unused_wd;
        assign unused_wd = en_i ^ clr_i ^ clk ^ rstn;
        assign expire_o  = 1'b0;
    end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-master round-robin Wishbone arbiter; grant held per CYC tenure, hung slaves aborted with ERR.
module wb_arbiter_2x1
    import wb_arb_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rstn,
    wb_if.slave        m0,
    wb_if.slave        m1,
    wb_if.master       s0,
    output logic [1:0] grant_o,
    output logic       timeout_o,
    output logic       timeout_id
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       tid_q, tid_d;
    logic       tout_q, tout_d;

    logic                       own_sel;
    logic                       own_cyc;
    logic                       own_stb;
    logic                       own_we;
    logic [WB_ADDR_WIDTH-1:0]   own_adr;
    logic [WB_DATA_WIDTH-1:0]   own_dat_w;
    logic [WB_DATA_WIDTH/8-1:0] own_sel_b;
    logic                       owning;
    logic                       wd_en, wd_clr, wd_expire;

    // During ABORT the owner is the master recorded in timeout_id.
    assign own_sel   = (state_q == ARB_OWN1) || ((state_q == ARB_ABORT) && tid_q);
    assign own_cyc   = own_sel ? m1.cyc   : m0.cyc;
    assign own_stb   = own_sel ? m1.stb   : m0.stb;
    assign own_we    = own_sel ? m1.we    : m0.we;
    assign own_adr   = own_sel ? m1.adr   : m0.adr;
    assign own_dat_w = own_sel ? m1.dat_w : m0.dat_w;
    assign own_sel_b = own_sel ? m1.sel   : m0.sel;
    assign owning    = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);

    assign wd_en  = owning && own_cyc && own_stb && !s0.ack && !s0.err;
    assign wd_clr = !wd_en || (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        tid_d        = tid_q;
        tout_d       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_owner_q ? ARB_OWN0 : ARB_OWN1;
                end else if (m0.cyc) begin
                    state_d = ARB_OWN0;
                end else if (m1.cyc) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                // A dropped CYC takes priority over a simultaneous expiry.
                if (!own_cyc) begin
                    state_d = arb_release(own_sel, m0.cyc, m1.cyc);
                end else if (wd_expire) begin
                    state_d = ARB_ABORT;
                    tout_d  = 1'b1;
                    tid_d   = own_sel;
                end
            end
            ARB_ABORT: begin
                if (!own_cyc) begin
                    state_d = arb_release(own_sel, m0.cyc, m1.cyc);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (state_d == ARB_OWN0) begin
            last_owner_d = 1'b0;
        end else if (state_d == ARB_OWN1) begin
            last_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
            tid_q        <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            tid_q        <= tid_d;
            tout_q       <= tout_d;
        end
    end

    always_comb begin
        s0.cyc   = 1'b0;
        s0.stb   = 1'b0;
        s0.we    = 1'b0;
        s0.adr   = '0;
        s0.dat_w = '0;
        s0.sel   = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = '0;
        if (owning) begin
            s0.cyc   = own_cyc;
            s0.stb   = own_stb;
            s0.we    = own_we;
            s0.adr   = own_adr;
            s0.dat_w = own_dat_w;
            s0.sel   = own_sel_b;
            if (own_sel) begin
                m1.ack   = s0.ack;
                m1.err   = s0.err;
                m1.dat_r = s0.dat_r;
            end else begin
                m0.ack   = s0.ack;
                m0.err   = s0.err;
                m0.dat_r = s0.dat_r;
            end
        end else if ((state_q == ARB_ABORT) && tout_q) begin
            // tout_q is high only on the first ABORT cycle; late slave ACKs are dropped.
            if (own_sel) begin
                m1.err = 1'b1;
            end else begin
                m0.err = 1'b1;
            end
        end
    end

    always_comb begin
        grant_o = 2'b00;
        case (state_q)
            ARB_OWN0:  grant_o = 2'b01;
            ARB_OWN1:  grant_o = 2'b10;
            ARB_ABORT: grant_o = tid_q ? 2'b10 : 2'b01;
            default:   grant_o = 2'b00;
        endcase
    end

    assign timeout_o  = tout_q;
    assign timeout_id = tid_q;

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Directed bench for wb_arbiter_2x1: tie-break, handover, burst hold, watchdog abort, async reset.
module tb_wb_arbiter_2x1;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] grant;
    logic       tout;
    logic       tid;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    wb_if #(.AW(32), .DW(32)) m0_if ();
    wb_if #(.AW(32), .DW(32)) m1_if ();
    wb_if #(.AW(32), .DW(32)) s0_if ();

    wb_arbiter_2x1 #(
        .WB_ADDR_WIDTH  (32),
        .WB_DATA_WIDTH  (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m0         (m0_if),
        .m1         (m1_if),
        .s0         (s0_if),
        .grant_o    (grant),
        .timeout_o  (tout),
        .timeout_id (tid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_drv(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.dat_w = d; m0_if.sel = 4'hf;
    endtask

    task automatic m1_drv(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.dat_w = d; m1_if.sel = 4'hf;
    endtask

    task automatic slv(input logic a, input logic e, input logic [31:0] d);
        s0_if.ack = a; s0_if.err = e; s0_if.dat_r = d;
    endtask

    initial begin
        rstn = 1'b0;
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        m1_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        tick();
        tick();
        chk("rst_grant", {30'd0, grant}, 32'h0);
        chk("rst_tout", {31'd0, tout}, 32'h0);
        chk("rst_tid", {31'd0, tid}, 32'h0);
        chk("rst_s0_cyc", {31'd0, s0_if.cyc}, 32'h0);
        chk("rst_m0_ack", {31'd0, m0_if.ack}, 32'h0);
        rstn = 1'b1;

        // 1: m0 single write, m1 idle
        tick();
        m0_drv(1, 1, 1, 32'hf0001000, 32'h000000a5);
        #1;
        chk("t1_idle_stb", {31'd0, s0_if.stb}, 32'h0);
        chk("t1_idle_grant", {30'd0, grant}, 32'h0);
        tick();
        chk("t1_grant", {30'd0, grant}, 32'h1);
        chk("t1_s0_stb", {31'd0, s0_if.stb}, 32'h1);
        chk("t1_s0_adr", s0_if.adr, 32'hf0001000);
        chk("t1_s0_dat", s0_if.dat_w, 32'h000000a5);
        chk("t1_s0_we", {31'd0, s0_if.we}, 32'h1);
        slv(1, 0, 32'h0);
        #1;
        chk("t1_m0_ack", {31'd0, m0_if.ack}, 32'h1);
        chk("t1_m1_ack", {31'd0, m1_if.ack}, 32'h0);
        tick();
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        tick();
        chk("t1_release", {30'd0, grant}, 32'h0);

        // 2: simultaneous request right after reset -> m0 first, then m1 with no bubble
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m0_drv(1, 1, 0, 32'h00000100, 32'h0);
        m1_drv(1, 1, 0, 32'h00000200, 32'h0);
        tick();
        chk("t2_grant0", {30'd0, grant}, 32'h1);
        chk("t2_adr0", s0_if.adr, 32'h00000100);
        slv(1, 0, 32'h11112222);
        #1;
        chk("t2_m0_dat", m0_if.dat_r, 32'h11112222);
        chk("t2_m1_dat", m1_if.dat_r, 32'h0);
        tick();
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        #1;
        chk("t2_hand_grant", {30'd0, grant}, 32'h1);
        tick();
        chk("t2_grant1", {30'd0, grant}, 32'h2);
        chk("t2_adr1", s0_if.adr, 32'h00000200);
        slv(1, 0, 32'h33334444);
        #1;
        chk("t2_m1_dat", m1_if.dat_r, 32'h33334444);
        tick();
        m1_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        tick();
        chk("t2_idle", {30'd0, grant}, 32'h0);

        // 3: m1 4-beat burst holds grant while m0 waits
        m1_drv(1, 1, 1, 32'h00000300, 32'h0);
        tick();
        chk("t3_grant1", {30'd0, grant}, 32'h2);
        m0_drv(1, 1, 0, 32'h00000400, 32'h0);
        for (int b = 0; b < 4; b++) begin
            m1_if.adr = 32'h00000300 + 32'(b * 4);
            slv(1, 0, 32'h0);
            #1;
            chk("t3_burst_grant", {30'd0, grant}, 32'h2);
            chk("t3_burst_m1ack", {31'd0, m1_if.ack}, 32'h1);
            chk("t3_burst_m0ack", {31'd0, m0_if.ack}, 32'h0);
            tick();
        end
        m1_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        #1;
        chk("t3_drop_grant", {30'd0, grant}, 32'h2);
        tick();
        chk("t3_grant0", {30'd0, grant}, 32'h1);
        chk("t3_adr0", s0_if.adr, 32'h00000400);
        slv(1, 0, 32'h0);
        tick();
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        slv(0, 0, 32'h0);
        tick();
        chk("t3_idle", {30'd0, grant}, 32'h0);

        // 4: slave never answers m0 read -> ERR on the 17th STB cycle
        m0_drv(1, 1, 0, 32'hf0002000, 32'h0);
        tick();
        chk("t4_stb", {31'd0, s0_if.stb}, 32'h1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("t4_wait_err", {31'd0, m0_if.err}, 32'h0);
            chk("t4_wait_tout", {31'd0, tout}, 32'h0);
        end
        chk("t4_c16_stb", {31'd0, s0_if.stb}, 32'h1);
        tick();
        chk("t4_err", {31'd0, m0_if.err}, 32'h1);
        chk("t4_tout", {31'd0, tout}, 32'h1);
        chk("t4_tid", {31'd0, tid}, 32'h0);
        chk("t4_s0_cyc", {31'd0, s0_if.cyc}, 32'h0);
        chk("t4_s0_stb", {31'd0, s0_if.stb}, 32'h0);
        slv(1, 0, 32'h0);
        tick();
        chk("t4_err_once", {31'd0, m0_if.err}, 32'h0);
        chk("t4_late_ack", {31'd0, m0_if.ack}, 32'h0);
        chk("t4_tout_pulse", {31'd0, tout}, 32'h0);
        chk("t4_tid_sticky", {31'd0, tid}, 32'h0);
        slv(0, 0, 32'h0);
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("t4_idle", {30'd0, grant}, 32'h0);

        // 5: ACK in the expiry cycle wins
        m0_drv(1, 1, 0, 32'hf0003000, 32'h0);
        tick();
        for (int i = 2; i <= 16; i++) begin
            tick();
        end
        slv(1, 0, 32'h5a5a5a5a);
        #1;
        chk("t5_ack", {31'd0, m0_if.ack}, 32'h1);
        chk("t5_dat", m0_if.dat_r, 32'h5a5a5a5a);
        tick();
        slv(0, 0, 32'h0);
        m0_drv(0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("t5_no_tout", {31'd0, tout}, 32'h0);
        chk("t5_no_err", {31'd0, m0_if.err}, 32'h0);
        chk("t5_grant", {30'd0, grant}, 32'h1);
        tick();
        chk("t5_idle", {30'd0, grant}, 32'h0);

        // 6: async reset during m1 burst beat 2, then tie-break returns to m0
        m1_drv(1, 1, 0, 32'h00000500, 32'h0);
        tick();
        slv(1, 0, 32'h0);
        tick();
        chk("t6_beat2_grant", {30'd0, grant}, 32'h2);
        chk("t6_beat2_cyc", {31'd0, s0_if.cyc}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_cyc", {31'd0, s0_if.cyc}, 32'h0);
        chk("t6_rst_grant", {30'd0, grant}, 32'h0);
        chk("t6_rst_ack", {31'd0, m1_if.ack}, 32'h0);
        chk("t6_rst_adr", s0_if.adr, 32'h0);
        slv(0, 0, 32'h0);
        m0_drv(1, 1, 1, 32'h00000600, 32'h00000077);
        tick();
        chk("t6_hold_grant", {30'd0, grant}, 32'h0);
        rstn = 1'b1;
        tick();
        chk("t6_tie_grant", {30'd0, grant}, 32'h1);
        chk("t6_tie_adr", s0_if.adr, 32'h00000600);
        chk("t6_tid", {31'd0, tid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
